dsp_psum_accum: RTL and testbench

DSP_PSUM_ACCUM -- requirements
Module: dsp_psum_accum

---
 rtl/dsp_psum_accum.sv | 175 +++++++++++++++++
 tb/tb_dsp_psum_accum.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_psum_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dsp_psum_accum                                                           |
// | Frame accumulator for DSP16_16 partial sums: 4 groups of 16 x 11-bit     |
// | lanes, two-stage pipeline (lane sum, then accumulate), held result.      |
// | Optional macro DSP_PSUM_OVF_SAT_EN: saturating accumulators with sticky  |
// | per-group overflow flags (otherwise wrap and out_ovf = 0).               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dsp_psum_accum #(
  parameter int LANES = 16,
  parameter int ACCW  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [703:0]      in_data,
  input  logic              in_last,
  input  logic [1:0]        fixpoint_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*ACCW-1:0] out_data,
  output logic [7:0]        out_beats,
  output logic [3:0]        out_ovf
);

  localparam int c_lane_w = 11;
  localparam int c_grp_w  = 176;
  localparam int c_groups = 4;
  localparam int c_sum_w  = 16;

  localparam logic signed [ACCW-1:0] c_pos16 = {{(ACCW-15){1'b0}}, 15'h7FFF};
  localparam logic signed [ACCW-1:0] c_neg16 = {{(ACCW-15){1'b1}}, 15'h0000};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_mode;
  logic       r_s1_valid;
  logic [7:0] r_beats;
  logic       w_ready;
  logic       w_accept;
  logic       w_release;
  logic       w_unsigned;

  // in_ready is forced low while rst is asserted, even though the FSM sits in IDLE
  assign w_ready    = ((r_state == IDLE) || (r_state == ACC)) && !rst;
  assign w_accept   = in_valid && w_ready;
  assign w_release  = (r_state == HOLD) && out_ready;
  // The first beat of a frame uses the live mode; later beats use the latched one
  assign w_unsigned = (r_state == IDLE) ? fixpoint_op[0] : r_mode[0];

  assign in_ready  = w_ready;
  assign out_valid = (r_state == HOLD);
  assign out_beats = r_beats;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = in_last ? DRAIN : ACC;
      ACC:     if (w_accept && in_last) w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = HOLD;
      HOLD:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode     <= 2'b00;
      r_s1_valid <= 1'b0;
      r_beats    <= 8'd0;
    end else begin
      r_s1_valid <= w_accept;
      if ((r_state == IDLE) && w_accept) begin
        r_mode <= fixpoint_op;
      end
      if (w_release) begin
        r_beats <= 8'd0;
      end else if (w_accept && (r_beats != 8'hFF)) begin
        r_beats <= r_beats + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < c_groups; g++) begin : g_group
    logic [c_lane_w-1:0] w_lane;
    logic [c_sum_w-1:0]  w_sum;
    logic [c_sum_w-1:0]  r_s1_sum;
    logic [ACCW-1:0]     r_acc;
    logic                r_ovf;
    logic [ACCW-1:0]     w_add;
    logic [ACCW-1:0]     w_res;
    logic [ACCW-1:0]     w_nxt;
    logic                w_ovf;
    logic [ACCW-1:0]     w_field;

    // 16 lanes of 11 bits always fit a 16-bit sum in either lane mode
    always_comb begin
      w_sum  = '0;
      w_lane = '0;
      for (int l = 0; l < LANES; l++) begin
        w_lane = in_data[g*c_grp_w + l*c_lane_w +: c_lane_w];
        if (w_unsigned) begin
          w_sum = w_sum + {{(c_sum_w-c_lane_w){1'b0}}, w_lane};
        end else begin
          w_sum = w_sum + {{(c_sum_w-c_lane_w){w_lane[c_lane_w-1]}}, w_lane};
        end
      end
    end

    assign w_add = {{(ACCW-c_sum_w){r_s1_sum[c_sum_w-1]}}, r_s1_sum};
    assign w_res = r_acc + w_add;

`ifdef DSP_PSUM_OVF_SAT_EN
    assign w_ovf = (r_acc[ACCW-1] == w_add[ACCW-1]) && (w_res[ACCW-1] != r_acc[ACCW-1]);
    assign w_nxt = !w_ovf          ? w_res :
                   r_acc[ACCW-1]   ? {1'b1, {(ACCW-1){1'b0}}} :
                                     {1'b0, {(ACCW-1){1'b1}}};
`else
    assign w_ovf = 1'b0;
    assign w_nxt = w_res;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1_sum <= '0;
        r_acc    <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_accept) begin
          r_s1_sum <= w_sum;
        end
        if (w_release) begin
          r_acc <= '0;
          r_ovf <= 1'b0;
        end else if (r_s1_valid) begin
          r_acc <= w_nxt;
          if (w_ovf) r_ovf <= 1'b1;
        end
      end
    end

    always_comb begin
      w_field = r_acc;
      if (r_mode[1]) begin
        if ($signed(r_acc) > c_pos16) begin
          w_field = c_pos16;
        end else if ($signed(r_acc) < c_neg16) begin
          w_field = c_neg16;
        end
      end
    end

    assign out_data[g*ACCW +: ACCW] = w_field;
    assign out_ovf[g]               = r_ovf;
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_psum_accum.sv
`default_nettype none
// Randomized and directed checks of dsp_psum_accum against a frame-level
// arithmetic reference model.
module tb_dsp_psum_accum;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [703:0] in_data;
  logic         in_last;
  logic [1:0]   fixpoint_op;
  logic         out_valid;
  logic         out_ready;
  logic [95:0]  out_data;
  logic [7:0]   out_beats;
  logic [3:0]   out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state for the frame in progress
  longint     m_acc [4];
  logic [3:0] m_ovf;
  int         m_beats;
  logic [1:0] m_mode;
  bit         m_first;

  dsp_psum_accum #(.LANES(16), .ACCW(24)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .fixpoint_op(fixpoint_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beats(out_beats), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [703:0] fill(input logic [10:0] v);
    logic [703:0] d;
    for (int i = 0; i < 64; i++) d[i*11 +: 11] = v;
    return d;
  endfunction

  function automatic logic [703:0] rand_data();
    logic [703:0] d;
    for (int i = 0; i < 22; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic longint gsum(input logic [703:0] d, input int g, input logic uns);
    longint s;
    logic [10:0] ln;
    s = 0;
    for (int l = 0; l < 16; l++) begin
      ln = d[g*176 + l*11 +: 11];
      if (uns || !ln[10]) s += longint'(ln);
      else                s += longint'(ln) - 2048;
    end
    return s;
  endfunction

  task automatic model_clear();
    for (int g = 0; g < 4; g++) m_acc[g] = 0;
    m_ovf   = 4'h0;
    m_beats = 0;
    m_mode  = 2'b00;
    m_first = 1'b1;
  endtask

  task automatic model_beat(input logic [703:0] d, input logic [1:0] op);
    longint t;
    if (m_first) begin
      m_mode  = op;
      m_first = 1'b0;
    end
    for (int g = 0; g < 4; g++) begin
      t = m_acc[g] + gsum(d, g, m_mode[0]);
`ifdef DSP_PSUM_OVF_SAT_EN
      if (t > 8388607)       begin t = 8388607;  m_ovf[g] = 1'b1; end
      else if (t < -8388608) begin t = -8388608; m_ovf[g] = 1'b1; end
`else
      t = t & 64'hFF_FFFF;
      if (t >= 8388608) t -= 16777216;
`endif
      m_acc[g] = t;
    end
    if (m_beats < 255) m_beats++;
  endtask

  function automatic logic [95:0] exp_data();
    logic [95:0] e;
    longint v;
    for (int g = 0; g < 4; g++) begin
      v = m_acc[g];
      if (m_mode[1]) begin
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
      end
      e[g*24 +: 24] = v[23:0];
    end
    return e;
  endfunction

  task automatic beat(input logic [703:0] d, input logic last, input logic [1:0] op, input bit gap);
    int waited;
    if (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid    = 1'b1;
    in_data     = d;
    in_last     = last;
    fixpoint_op = op;
    waited      = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      check("ready_timeout", 96'(in_ready), 96'(1));
    end else begin
      @(posedge clk);
      model_beat(d, op);
    end
  endtask

  task automatic finish_frame(input int hold, input bit keep_valid);
    logic [95:0] e;
    e = exp_data();
    @(negedge clk);
    in_valid  = keep_valid;
    in_data   = rand_data();
    in_last   = 1'b0;
    out_ready = 1'b0;
    check("lat_drain", 96'(out_valid), 96'(0));
    @(negedge clk);
    check("lat_hold", 96'(out_valid), 96'(1));
    check("data", out_data, e);
    check("beats", 96'(out_beats), 96'(m_beats));
    check("ovf", 96'(out_ovf), 96'(m_ovf));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_ready", 96'(in_ready), 96'(0));
      check("bp_valid", 96'(out_valid), 96'(1));
      check("bp_data", out_data, e);
      check("bp_beats", 96'(out_beats), 96'(m_beats));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("rel_valid", 96'(out_valid), 96'(0));
    check("rel_ready", 96'(in_ready), 96'(1));
    check("rel_data", out_data, 96'(0));
    check("rel_beats", 96'(out_beats), 96'(0));
    model_clear();
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    fixpoint_op = 2'b00;
    out_ready   = 1'b0;
    model_clear();

    #1;
    check("rst_ready", 96'(in_ready), 96'(0));
    check("rst_valid", 96'(out_valid), 96'(0));
    check("rst_data", out_data, 96'(0));
    check("rst_beats", 96'(out_beats), 96'(0));
    check("rst_ovf", 96'(out_ovf), 96'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 96'(in_ready), 96'(1));

    // Signed 3-beat frame of ones: 48 per group
    for (int i = 0; i < 3; i++) beat(fill(11'd1), i == 2, 2'b00, 1'b0);
    check("ones_model", 96'(m_acc[0]), 96'(48));
    finish_frame(0, 1'b0);

    // Unsigned single-beat frames, raw and saturating output mode
    beat(fill(11'h7FF), 1'b1, 2'b01, 1'b0);
    finish_frame(0, 1'b0);
    beat(fill(11'h7FF), 1'b1, 2'b11, 1'b0);
    finish_frame(0, 1'b0);
    for (int i = 0; i < 3; i++) beat(fill(11'h7FF), i == 2, 2'b11, 1'b0);
    finish_frame(0, 1'b0);

    // Backpressure in HOLD with the producer still presenting data
    for (int i = 0; i < 2; i++) beat(rand_data(), i == 1, 2'b00, 1'b0);
    finish_frame(5, 1'b1);
    beat(fill(11'd1), 1'b1, 2'b00, 1'b0);
    finish_frame(0, 1'b0);

    // Mode change mid-frame is ignored: 11'h7FF stays -1
    beat(fill(11'h7FF), 1'b0, 2'b00, 1'b0);
    beat(fill(11'h7FF), 1'b1, 2'b01, 1'b0);
    check("latch_model", 96'(m_acc[2]), 96'(-32));
    finish_frame(0, 1'b0);

    // Long frame drives accumulators past the 24-bit range and beats past 255
    for (int i = 0; i < 600; i++) beat(fill(11'h400), i == 599, 2'b00, 1'b0);
    finish_frame(0, 1'b0);

    // Asynchronous reset mid-frame
    beat(rand_data(), 1'b0, 2'b00, 1'b0);
    beat(rand_data(), 1'b0, 2'b00, 1'b0);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mid_rst_ready", 96'(in_ready), 96'(0));
    check("mid_rst_valid", 96'(out_valid), 96'(0));
    check("mid_rst_data", out_data, 96'(0));
    check("mid_rst_beats", 96'(out_beats), 96'(0));
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    beat(fill(11'd2), 1'b1, 2'b00, 1'b0);
    finish_frame(0, 1'b0);

    // Reset while holding a result discards it
    beat(fill(11'd3), 1'b1, 2'b00, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("hold_before_rst", 96'(out_valid), 96'(1));
    rst = 1'b1;
    #1;
    check("hold_rst_valid", 96'(out_valid), 96'(0));
    check("hold_rst_data", out_data, 96'(0));
    @(negedge clk);
    rst = 1'b0;
    model_clear();

    // Random frames: random data, modes, lengths, gaps and hold times
    for (int f = 0; f < 8; f++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        beat(rand_data(), i == len - 1, 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      end
      finish_frame($urandom_range(0, 2), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
